// File: rtl/mm_feeder.sv
// Stream feeder for the MM core: fetches matrices A then B row-major from a
// 1-cycle-latency byte SRAM and presents them one element per cycle with row/matrix flags.
module mm_feeder #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       shape_in,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              ready,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              busy,
    output logic              in_valid,
    output logic [7:0]        in_data,
    output logic              col_end,
    output logic              row_end
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREFETCH = 2'd1,
        S_STREAM   = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        c1_q, c2_q, col_q;
    logic [7:0]        size_a_q;
    logic [8:0]        total_q, fetch_q, elem_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rvalid_q;
    logic [7:0]        fifo_q [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        count_q;

    logic [7:0] size_a_s, size_b_s;
    logic [8:0] total_s;
    logic [3:0] width_s;
    logic       accept_s, stream_s, pop_s, last_s, col_end_s, row_end_s, fetch_s;

    assign size_a_s  = {4'd0, shape_in[15:12]} * {4'd0, shape_in[11:8]};
    assign size_b_s  = {4'd0, shape_in[7:4]} * {4'd0, shape_in[3:0]};
    // A degenerate job is recorded as zero elements so the fetch engine stays quiet.
    assign total_s   = ((size_a_s == 8'd0) || (size_b_s == 8'd0)) ? 9'd0
                     : ({1'b0, size_a_s} + {1'b0, size_b_s});
    assign accept_s  = (state_q == S_IDLE) && start;
    assign stream_s  = (state_q == S_STREAM);
    assign pop_s     = stream_s && !busy;
    assign last_s    = (elem_q == (total_q - 9'd1));
    assign width_s   = (elem_q < {1'b0, size_a_q}) ? c1_q : c2_q;
    assign col_end_s = (col_q == (width_s - 4'd1));
    assign row_end_s = (elem_q == ({1'b0, size_a_q} - 9'd1)) || last_s;
    // Counting this cycle's pop lets a read issue while the FIFO looks full, avoiding bubbles.
    assign fetch_s   = ((state_q == S_PREFETCH) || stream_s) && (fetch_q < total_q) &&
                       (({1'b0, count_q} + {2'b00, rvalid_q}) < (3'd2 + {2'b00, pop_s}));

    // Next-state logic of the job sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PREFETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREFETCH: begin
                if (total_q == 9'd0) begin
                    state_d = S_DONE;
                end else if (rvalid_q) begin
                    state_d = S_STREAM;
                end else begin
                    state_d = S_PREFETCH;
                end
            end
            S_STREAM: begin
                if (pop_s && last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job descriptor latch and SRAM read address generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            c1_q     <= 4'd0;
            c2_q     <= 4'd0;
            size_a_q <= 8'd0;
            total_q  <= 9'd0;
            addr_q   <= {ADDR_W{1'b0}};
            fetch_q  <= 9'd0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= fetch_s;
            if (accept_s) begin
                c1_q     <= shape_in[11:8];
                c2_q     <= shape_in[3:0];
                size_a_q <= size_a_s;
                total_q  <= total_s;
                addr_q   <= base_addr;
                fetch_q  <= 9'd0;
            end else if (fetch_s) begin
                addr_q  <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                fetch_q <= fetch_q + 9'd1;
            end
        end
    end

    // Two-entry FIFO between SRAM return data and the MM stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q[0] <= 8'd0;
            fifo_q[1] <= 8'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (rvalid_q) begin
                fifo_q[wr_ptr_q] <= mem_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, rvalid_q} - {1'b0, pop_s};
        end
    end

    // Element and column counters advance only when MM takes an element.
    always_ff @(posedge clk) begin
        if (rst) begin
            elem_q <= 9'd0;
            col_q  <= 4'd0;
        end else if (accept_s) begin
            elem_q <= 9'd0;
            col_q  <= 4'd0;
        end else if (pop_s) begin
            elem_q <= elem_q + 9'd1;
            col_q  <= col_end_s ? 4'd0 : (col_q + 4'd1);
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign done     = (state_q == S_DONE);
    assign mem_rd   = fetch_s;
    assign mem_addr = addr_q;
    assign in_valid = stream_s;
    assign in_data  = stream_s ? fifo_q[rd_ptr_q] : 8'd0;
    assign col_end  = stream_s && col_end_s;
    assign row_end  = stream_s && row_end_s;

endmodule
